exec_unit_sched: RTL and testbench
==================================

# exec_unit_sched

Issue scheduler and scoreboard for the execute stage's multi-cycle units: integer MUL/DIV and FPU add/sub, mul, inv and sqrt. It sits between decode and execute. It decides each cycle whether the presented instruction may issue, pulses the start strobe of the selected unit, and reserves the single writeback result slot. It also raises RAW/WAW stalls against results still in flight and emits the writeback valid/destination when each result lands.

## Interface
- LAT_ALU, 1, result latency of single-cycle integer ops (unit 0)
- LAT_MUL, 3, MUL32_32 latency (unit 1, pipelined)
- LAT_DIV, 36, DIV32 latency (unit 2, non-pipelined)
- LAT_FADD, 2, fadd/fsub latency (unit 3, pipelined)
- LAT_FMUL, 2, fmul latency (unit 4, pipelined)
- LAT_FINV, 4, finv latency (unit 5, pipelined)
- LAT_FSQRT, 4, fsqrt latency (unit 6, pipelined)
- clk  in  1  clock. One clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous; discard all in-flight results
- issue_valid  in  1  decode presents an instruction
- issue_unit  in  3  target unit 0..6; value 7 is illegal and is treated as not valid
- issue_rd  in  6  destination register: 0-31 int, 32-63 float
- rs_valid, rt_valid  in  1 each  source operand is used
- issue_rs, issue_rt  in  6 each  source registers
- issue_ready  out  1  instruction accepted this cycle; combinational
- unit_start  out  7  one-hot start pulse, registered, asserted the cycle after accept
- wb_valid  out  1  a result lands this cycle
- wb_unit  out  3  unit producing the result
- wb_rd  out  6  destination of the result
- div_busy  out  1  divider occupied
- pending  out  7  count of in-flight entries

## Operation
- Each in-flight entry holds {unit, rd, remaining}. remaining = number of cycles until writeback. At most 64 entries, one per remaining value; store them as a shift register indexed by remaining.
- Every legal parameter value is 1..63. Values outside this range are an elaboration error.
- For an instruction with unit u and latency L, issue_ready = issue_valid & !rst & !flush & all of the following:
  - no entry has remaining == L (result-slot conflict);
  - not (u == 2 & div_busy);
  - no RAW hazard: rs_valid & issue_rs != 0 & issue_rs matches an entry with remaining ≥ 1. The same rule applies to rt. Entries at remaining 0 are covered by the ew forwarding path;
  - no WAW hazard: issue_rd != 0 & issue_rd matches any entry with remaining ≥ 1.
- Accept at cycle T:
  - the entry is inserted with remaining = L − 1 as of cycle T+1;
  - unit_start[u] = 1 in cycle T+1.
- rd == 0 entries still reserve their result slot but never cause a hazard.
- Each cycle, every entry's remaining decrements. An entry at remaining 0 drives wb_valid/wb_unit/wb_rd for that cycle, then retires.
- Divider occupancy:
  - a DIV accept sets div_busy from T+1;
  - div_busy clears at the end of cycle T+LAT_DIV−1;
  - a second DIV may therefore be accepted in cycle T+LAT_DIV.
- flush:
  - all entries are cleared at the next edge, div_busy is cleared and pending is zeroed;
  - issue_ready is 0 in the flush cycle;
  - unit_start is not asserted for that cycle;
  - a wb due in the flush cycle is still presented. Only future writebacks are dropped.
- Simultaneous accept and retire in the same cycle: pending is unchanged.

## Timing
- Reset values: wb_valid 0, wb_unit 0, wb_rd 0, unit_start 0, div_busy 0, pending 0, all entries invalid.
- issue_ready is 0 while rst is asserted.
- rst is asserted asynchronously and takes effect mid-operation: all in-flight work is abandoned with no writeback.
- Accept in cycle T with latency L gives wb_valid in exactly cycle T+L.
- Combinational paths:
  - issue_ready depends combinationally on the issue inputs and on registered state only;
  - no combinational path exists from any issue input to wb_*, unit_start, div_busy or pending.
- Throughput: one accept per cycle whenever there is no conflict.

## Test plan
- After reset release, MUL to r5 at T=0 -> unit_start[1] at T=1; wb_valid, wb_unit=1, wb_rd=5 at T=3; pending returns 0 at T=4.
- FMUL (L=2) at T=0, then ALU (L=1) at T=1 -> ALU blocked at T=1 by slot conflict (issue_ready=0). Re-presented at T=2, it is accepted and writes back at T=3.
- DIV at T=0, second DIV presented every cycle -> stalled through T=35, accepted at T=36; the first wb lands at T=36.
- MUL to r7 at T=0; ADD with rs=r7 at T=1 -> stalled at T=1 and T=2, accepted at T=3.
  - Same test with rd=r0 -> no stall.
- FSQRT to f3 (reg 35) at T=0; FADD to 35 at T=1 -> WAW stall until T=4.
- DIV in flight, then flush at T=10 -> div_busy=0 and pending=0 at T=11; no wb at T=36.
  - Same test with async rst at T=5 -> all outputs are 0 immediately.

Source files
------------

// File: rtl/exec_unit_sched.sv
// Issue scheduler and result-slot scoreboard for the multi-cycle execute units.
// In-flight results sit in a shift register indexed by cycles-to-writeback.
module exec_unit_sched #(
  parameter int LAT_ALU   = 1,
  parameter int LAT_MUL   = 3,
  parameter int LAT_DIV   = 36,
  parameter int LAT_FADD  = 2,
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FINV  = 4,
  parameter int LAT_FSQRT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic [2:0] issue_unit,
  input  logic [5:0] issue_rd,
  input  logic       rs_valid,
  input  logic       rt_valid,
  input  logic [5:0] issue_rs,
  input  logic [5:0] issue_rt,
  output logic       issue_ready,
  output logic [6:0] unit_start,
  output logic       wb_valid,
  output logic [2:0] wb_unit,
  output logic [5:0] wb_rd,
  output logic       div_busy,
  output logic [6:0] pending
);

  localparam int N = 64;

  if (LAT_ALU < 1 || LAT_ALU > 63 || LAT_MUL < 1 || LAT_MUL > 63 ||
      LAT_DIV < 1 || LAT_DIV > 63 || LAT_FADD < 1 || LAT_FADD > 63 ||
      LAT_FMUL < 1 || LAT_FMUL > 63 || LAT_FINV < 1 || LAT_FINV > 63 ||
      LAT_FSQRT < 1 || LAT_FSQRT > 63) begin : g_bad_lat
    $error("exec_unit_sched: every latency must be within 1..63");
  end

  // Entry i holds the result due i cycles from now; invalid entries keep zero fields.
  logic [N-1:0] ent_valid;
  logic [2:0]   ent_unit [N];
  logic [5:0]   ent_rd   [N];
  logic [5:0]   div_cnt;

  logic       unit_ok;
  logic [5:0] lat;
  logic       slot_busy;
  logic       raw_hit;
  logic       waw_hit;

  always_comb begin
    unit_ok = 1'b1;
    lat     = 6'd1;
    case (issue_unit)
      3'd0:    lat = 6'(LAT_ALU);
      3'd1:    lat = 6'(LAT_MUL);
      3'd2:    lat = 6'(LAT_DIV);
      3'd3:    lat = 6'(LAT_FADD);
      3'd4:    lat = 6'(LAT_FMUL);
      3'd5:    lat = 6'(LAT_FINV);
      3'd6:    lat = 6'(LAT_FSQRT);
      default: unit_ok = 1'b0;
    endcase
  end

  // Entry 0 is landing this cycle and is reachable through forwarding, so hazards skip it.
  always_comb begin
    slot_busy = 1'b0;
    raw_hit   = 1'b0;
    waw_hit   = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (ent_valid[i]) begin
        if (6'(i) == lat) slot_busy = 1'b1;
        if (ent_rd[i] != 6'd0) begin
          if (rs_valid && issue_rs == ent_rd[i]) raw_hit = 1'b1;
          if (rt_valid && issue_rt == ent_rd[i]) raw_hit = 1'b1;
          if (issue_rd == ent_rd[i])             waw_hit = 1'b1;
        end
      end
    end
  end

  assign div_busy = (div_cnt != 6'd0);

  assign issue_ready = issue_valid && unit_ok && !rst && !flush && !slot_busy &&
                       !((issue_unit == 3'd2) && div_busy) && !raw_hit && !waw_hit;

  assign wb_valid = ent_valid[0];
  assign wb_unit  = ent_unit[0];
  assign wb_rd    = ent_rd[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid  <= '0;
      for (int i = 0; i < N; i++) begin
        ent_unit[i] <= 3'd0;
        ent_rd[i]   <= 6'd0;
      end
      div_cnt    <= 6'd0;
      pending    <= 7'd0;
      unit_start <= 7'd0;
    end else if (flush) begin
      ent_valid  <= '0;
      for (int i = 0; i < N; i++) begin
        ent_unit[i] <= 3'd0;
        ent_rd[i]   <= 6'd0;
      end
      div_cnt    <= 6'd0;
      pending    <= 7'd0;
      unit_start <= 7'd0;
    end else begin
      ent_valid <= {1'b0, ent_valid[N-1:1]};
      for (int i = 0; i < N - 1; i++) begin
        ent_unit[i] <= ent_unit[i+1];
        ent_rd[i]   <= ent_rd[i+1];
      end
      ent_unit[N-1] <= 3'd0;
      ent_rd[N-1]   <= 6'd0;
      // The slot check guarantees the shifted-in entry at lat-1 is empty.
      if (issue_ready) begin
        ent_valid[lat - 6'd1] <= 1'b1;
        ent_unit[lat - 6'd1]  <= issue_unit;
        ent_rd[lat - 6'd1]    <= issue_rd;
      end

      unit_start <= issue_ready ? (7'd1 << issue_unit) : 7'd0;

      if (issue_ready && issue_unit == 3'd2) div_cnt <= 6'(LAT_DIV - 1);
      else if (div_cnt != 6'd0)              div_cnt <= div_cnt - 6'd1;

      pending <= pending + {6'd0, issue_ready} - {6'd0, ent_valid[0]};
    end
  end

endmodule

// File: tb/tb_exec_unit_sched.sv
// Directed bench for exec_unit_sched: issue decisions checked inline,
// writebacks matched by a forked monitor against an expected queue.
module tb_exec_unit_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       issue_valid;
  logic [2:0] issue_unit;
  logic [5:0] issue_rd;
  logic       rs_valid;
  logic       rt_valid;
  logic [5:0] issue_rs;
  logic [5:0] issue_rt;
  logic       issue_ready;
  logic [6:0] unit_start;
  logic       wb_valid;
  logic [2:0] wb_unit;
  logic [5:0] wb_rd;
  logic       div_busy;
  logic [6:0] pending;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // {due cycle[40:9], unit[8:6], rd[5:0]}
  logic [40:0] exp_q[$];

  exec_unit_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_rd(issue_rd),
    .rs_valid(rs_valid), .rt_valid(rt_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_ready(issue_ready), .unit_start(unit_start),
    .wb_valid(wb_valid), .wb_unit(wb_unit), .wb_rd(wb_rd),
    .div_busy(div_busy), .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input logic [2:0] u);
    case (u)
      3'd0: return 1;
      3'd1: return 3;
      3'd2: return 36;
      3'd3: return 2;
      3'd4: return 2;
      3'd5: return 4;
      3'd6: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    rs_valid    = 1'b0;
    rt_valid    = 1'b0;
  endtask

  task automatic present(input logic [2:0] u, input logic [5:0] rd,
                         input logic rsv, input logic [5:0] rs,
                         input logic rtv, input logic [5:0] rt);
    issue_valid = 1'b1;
    issue_unit  = u;
    issue_rd    = rd;
    rs_valid    = rsv;
    issue_rs    = rs;
    rt_valid    = rtv;
    issue_rt    = rt;
  endtask

  // Presents for one cycle; an expected accept schedules its writeback.
  task automatic try_issue(input string name, input logic [2:0] u, input logic [5:0] rd,
                           input logic rsv, input logic [5:0] rs,
                           input logic rtv, input logic [5:0] rt, input logic exp);
    present(u, rd, rsv, rs, rtv, rt);
    #1;
    check(name, 64'(issue_ready), 64'(exp));
    if (exp) exp_q.push_back({32'(cyc + lat_of(u)), u, rd});
    step();
    idle();
  endtask

  task automatic monitor();
    int found;
    forever begin
      @(negedge clk);
      if (!rst) begin
        found = -1;
        foreach (exp_q[i]) if (exp_q[i][40:9] == 32'(cyc)) found = i;
        if (found >= 0) begin
          check("wb_valid", 64'(wb_valid), 64'd1);
          check("wb_unit_rd", 64'({wb_unit, wb_rd}), 64'(exp_q[found][8:0]));
          exp_q.delete(found);
        end else begin
          check("wb_idle", 64'(wb_valid), 64'd0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    issue_unit = 3'd0; issue_rd = 6'd0; issue_rs = 6'd0; issue_rt = 6'd0;
    idle();
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    present(3'd1, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    check("ready_in_rst", 64'(issue_ready), 64'd0);
    idle();
    step();
    rst = 1'b0;
    #1;
    check("rst_wb", 64'({wb_valid, wb_unit, wb_rd}), 64'd0);
    check("rst_start", 64'(unit_start), 64'd0);
    check("rst_div_busy", 64'(div_busy), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    step();

    // MUL r5: start at T1, wb at T3, pending back to 0 at T4
    try_issue("mul_r5", 3'd1, 6'd5, 0, 0, 0, 0, 1);
    check("mul_start_t1", 64'(unit_start), 64'b0000010);
    check("mul_pending_t1", 64'(pending), 64'd1);
    step();
    check("mul_start_t2", 64'(unit_start), 64'd0);
    step();
    step();
    check("mul_pending_t4", 64'(pending), 64'd0);

    // back-to-back throughput
    try_issue("tp_0", 3'd1, 6'd1, 0, 0, 0, 0, 1);
    try_issue("tp_1", 3'd1, 6'd2, 0, 0, 0, 0, 1);
    try_issue("tp_2", 3'd1, 6'd3, 0, 0, 0, 0, 1);
    check("tp_pending", 64'(pending), 64'd3);
    repeat (4) step();

    // slot conflict: FMUL then ALU
    try_issue("fmul", 3'd4, 6'd10, 0, 0, 0, 0, 1);
    try_issue("alu_slot_block", 3'd0, 6'd11, 0, 0, 0, 0, 0);
    try_issue("alu_slot_ok", 3'd0, 6'd11, 0, 0, 0, 0, 1);
    try_issue("illegal_unit", 3'd7, 6'd1, 0, 0, 0, 0, 0);
    repeat (3) step();

    // divider occupancy
    try_issue("div_a", 3'd2, 6'd12, 0, 0, 0, 0, 1);
    check("div_busy_t1", 64'(div_busy), 64'd1);
    for (int k = 1; k <= 36; k++) begin
      if (k == 35) check("div_busy_t35", 64'(div_busy), 64'd1);
      if (k == 36) check("div_busy_t36", 64'(div_busy), 64'd0);
      try_issue($sformatf("div_b_t%0d", k), 3'd2, 6'd13, 0, 0, 0, 0, (k == 36));
    end
    check("div_busy_t37", 64'(div_busy), 64'd1);
    repeat (38) step();

    // RAW on rs
    try_issue("mul_r7", 3'd1, 6'd7, 0, 0, 0, 0, 1);
    try_issue("raw_t1", 3'd0, 6'd8, 1, 6'd7, 0, 0, 0);
    try_issue("raw_t2", 3'd0, 6'd8, 1, 6'd7, 0, 0, 0);
    try_issue("raw_t3", 3'd0, 6'd8, 1, 6'd7, 0, 0, 1);
    repeat (4) step();
    // rd=r0 producer never stalls a reader of r0
    try_issue("mul_r0", 3'd1, 6'd0, 0, 0, 0, 0, 1);
    try_issue("raw_r0", 3'd0, 6'd8, 1, 6'd0, 0, 0, 1);
    repeat (4) step();
    // RAW on rt, then unused rs naming the busy reg
    try_issue("mul_r9", 3'd1, 6'd9, 0, 0, 0, 0, 1);
    try_issue("raw_rt", 3'd0, 6'd8, 0, 0, 1, 6'd9, 0);
    try_issue("rs_unused", 3'd3, 6'd8, 0, 6'd9, 0, 0, 1);
    repeat (4) step();

    // WAW on float reg 35
    try_issue("fsqrt_f3", 3'd6, 6'd35, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 4; k++)
      try_issue($sformatf("waw_t%0d", k), 3'd3, 6'd35, 0, 0, 0, 0, (k == 4));
    repeat (4) step();

    // flush at T10 with a MUL wb due in that cycle
    try_issue("div_fl", 3'd2, 6'd20, 0, 0, 0, 0, 1);
    repeat (6) step();
    try_issue("mul_fl", 3'd1, 6'd21, 0, 0, 0, 0, 1);
    step();
    step();
    flush = 1'b1;
    present(3'd0, 6'd22, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    check("flush_ready", 64'(issue_ready), 64'd0);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (int'(exp_q[i][40:9]) > cyc) exp_q.delete(i);
    step();
    flush = 1'b0;
    idle();
    check("flush_div_busy", 64'(div_busy), 64'd0);
    check("flush_pending", 64'(pending), 64'd0);
    check("flush_start", 64'(unit_start), 64'd0);
    repeat (30) step();

    // asynchronous reset mid-operation
    try_issue("div_rst", 3'd2, 6'd20, 0, 0, 0, 0, 1);
    try_issue("mul_rst", 3'd1, 6'd23, 0, 0, 0, 0, 1);
    repeat (3) step();
    #1;
    rst = 1'b1;
    present(3'd0, 6'd24, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    exp_q.delete();
    check("arst_ready", 64'(issue_ready), 64'd0);
    check("arst_wb", 64'({wb_valid, wb_unit, wb_rd}), 64'd0);
    check("arst_start", 64'(unit_start), 64'd0);
    check("arst_div_busy", 64'(div_busy), 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    idle();
    step();
    step();
    rst = 1'b0;
    repeat (40) step();
    check("end_pending", 64'(pending), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
